// File: rtl/pc_sequencer_pkg.sv
// Shared codes for the PC sequencer: next-PC source selects,
// FSM state encodings and the default datapath width.
package pc_sequencer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_src_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_TRAP  = 3'd4
  } state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect resolution: target address, whether the
// redirect is taken, and whether the target is word-misaligned.
module next_pc_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_pc_src,
  input  logic            i_branch,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  output logic [XLEN-1:0] o_target,
  output logic            o_taken,
  output logic            o_misaligned
);
  import pc_sequencer_pkg::*;

  pc_src_e         w_src;
  logic [XLEN-1:0] w_pc_rel;
  logic [XLEN-1:0] w_reg_rel;

  assign w_src     = pc_src_e'(i_pc_src);
  assign w_pc_rel  = i_pc + i_imm;
  assign w_reg_rel = i_rs1 + i_imm;

  always_comb begin
    o_taken  = 1'b0;
    o_target = w_pc_rel;
    unique case (w_src)
      PC_SEQ:    o_taken = 1'b0;
      PC_BRANCH: o_taken = i_branch;
      PC_JAL:    o_taken = 1'b1;
      PC_JALR: begin
        o_taken  = 1'b1;
        o_target = {w_reg_rel[XLEN-1:1], 1'b0};
      end
      default:   o_taken = 1'b0;
    endcase
  end

  assign o_misaligned = o_taken & (o_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch/execute sequencing FSM with post-redirect
// flush window and a sticky misaligned-target trap.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            instr_valid,
  input  logic            stall,
  input  logic [1:0]      pc_src,
  input  logic            branch,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush,
  output logic            trap,
  output logic [XLEN-1:0] trap_addr
);
  import pc_sequencer_pkg::*;

  // Counter holds remaining flush cycles minus one.
  localparam logic [3:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_e          r_state;
  state_e          w_state_nx;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nx;
  logic [XLEN-1:0] r_trap_addr;
  logic [XLEN-1:0] w_trap_addr_nx;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nx;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_misaligned;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + XLEN'(4);

  next_pc_calc #(.XLEN(XLEN)) u_calc (
    .i_pc         (r_pc),
    .i_pc_src     (pc_src),
    .i_branch     (branch),
    .i_imm        (imm),
    .i_rs1        (rs1),
    .o_target     (w_target),
    .o_taken      (w_taken),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_VECTOR;
      r_trap_addr <= '0;
      r_cnt       <= 4'd0;
    end else begin
      r_state     <= w_state_nx;
      r_pc        <= w_pc_nx;
      r_trap_addr <= w_trap_addr_nx;
      r_cnt       <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_pc_nx        = r_pc;
    w_trap_addr_nx = r_trap_addr;
    w_cnt_nx       = r_cnt;
    unique case (r_state)
      ST_IDLE:  w_state_nx = ST_FETCH;
      ST_FETCH: if (imem_ack) w_state_nx = ST_EXEC;
      ST_EXEC: begin
        if (!stall) begin
          if (!w_taken) begin
            w_pc_nx    = w_pc_plus4;
            w_state_nx = ST_FETCH;
          end else if (w_misaligned) begin
            w_trap_addr_nx = w_target;
            w_state_nx     = ST_TRAP;
          end else begin
            w_pc_nx = w_target;
            if (FLUSH_CYCLES > 0) begin
              w_state_nx = ST_FLUSH;
              w_cnt_nx   = FLUSH_LOAD;
            end else begin
              w_state_nx = ST_FETCH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (r_cnt == 4'd0) w_state_nx = ST_FETCH;
        else               w_cnt_nx   = r_cnt - 4'd1;
      end
      ST_TRAP:  w_state_nx = ST_TRAP;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_EXEC);
  assign flush       = (r_state == ST_FLUSH);
  assign trap        = (r_state == ST_TRAP);
  assign trap_addr   = r_trap_addr;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two builds (2 and 0 flush cycles) checked
// every cycle against a behavioural model, plus directed literals.
module tb_pc_sequencer;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_FLUSH = 3;
  localparam int M_TRAP  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;

  logic [1:0]        req, iv, fl, tr;
  logic [1:0][31:0]  pcv, p4, ta;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  int          fc [2] = '{2, 0};
  int          m_st [2];
  int          m_left [2];
  logic [31:0] m_pc [2];
  logic [31:0] m_ta [2];

  always #5 clk = ~clk;

  pc_sequencer #(.FLUSH_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset),
    .imem_req(req[0]), .imem_ack(imem_ack),
    .instr_valid(iv[0]), .stall(stall),
    .pc_src(pc_src), .branch(branch),
    .imm(imm), .rs1(rs1),
    .pc(pcv[0]), .pc_plus4(p4[0]),
    .flush(fl[0]), .trap(tr[0]),
    .trap_addr(ta[0])
  );

  pc_sequencer #(.FLUSH_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset),
    .imem_req(req[1]), .imem_ack(imem_ack),
    .instr_valid(iv[1]), .stall(stall),
    .pc_src(pc_src), .branch(branch),
    .imm(imm), .rs1(rs1),
    .pc(pcv[1]), .pc_plus4(p4[1]),
    .flush(fl[1]), .trap(tr[1]),
    .trap_addr(ta[1])
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]   = M_IDLE;
      m_pc[k]   = 32'h0;
      m_ta[k]   = 32'h0;
      m_left[k] = 0;
    end
  endfunction

  function automatic void model_step(int k);
    logic [31:0] tgt;
    case (m_st[k])
      M_IDLE:  m_st[k] = M_FETCH;
      M_FETCH: if (imem_ack) m_st[k] = M_EXEC;
      M_EXEC: if (!stall) begin
        if (pc_src == 2'd0 || (pc_src == 2'd1 && !branch)) begin
          m_pc[k] = m_pc[k] + 32'd4;
          m_st[k] = M_FETCH;
        end else begin
          if (pc_src == 2'd3) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
          else                tgt = m_pc[k] + imm;
          if (tgt % 4 != 0) begin
            m_ta[k] = tgt;
            m_st[k] = M_TRAP;
          end else begin
            m_pc[k] = tgt;
            if (fc[k] > 0) begin
              m_st[k]   = M_FLUSH;
              m_left[k] = fc[k];
            end else begin
              m_st[k] = M_FETCH;
            end
          end
        end
      end
      M_FLUSH: begin
        m_left[k]--;
        if (m_left[k] == 0) m_st[k] = M_FETCH;
      end
      default: m_st[k] = M_TRAP;
    endcase
  endfunction

  always @(posedge clk)
    if (!reset)
      for (int k = 0; k < 2; k++) model_step(k);

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d.imem_req", k), 32'(req[k]),
            32'(m_st[k] == M_FETCH));
        chk($sformatf("d%0d.instr_valid", k), 32'(iv[k]),
            32'(m_st[k] == M_EXEC));
        chk($sformatf("d%0d.flush", k), 32'(fl[k]),
            32'(m_st[k] == M_FLUSH));
        chk($sformatf("d%0d.trap", k), 32'(tr[k]),
            32'(m_st[k] == M_TRAP));
        chk($sformatf("d%0d.trap_addr", k), ta[k], m_ta[k]);
        chk($sformatf("d%0d.pc", k), pcv[k], m_pc[k]);
        chk($sformatf("d%0d.pc_plus4", k), p4[k], m_pc[k] + 32'd4);
      end
    end
  end

  task automatic wait_exec(input int k);
    int n;
    n = 0;
    while (!iv[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d.reach_exec", k), 32'(iv[k]), 32'd1);
  endtask

  task automatic do_exec(input int k, input logic [1:0] s,
                         input logic b, input logic [31:0] im,
                         input logic [31:0] r,
                         input logic [31:0] exp_pc, input int nst);
    wait_exec(k);
    chk("exec_pc", pcv[k], exp_pc);
    pc_src = s;
    branch = b;
    imm    = im;
    rs1    = r;
    if (nst > 0) begin
      stall = 1'b1;
      repeat (nst) begin
        @(negedge clk);
        chk("stall_iv", 32'(iv[k]), 32'd1);
        chk("stall_pc", pcv[k], exp_pc);
      end
      stall = 1'b0;
    end
    @(negedge clk);
    pc_src = 2'd0;
    branch = 1'b0;
    imm    = '0;
    rs1    = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_req", 32'(req[0]), 32'd0);
    chk("rst_async_pc", pcv[0], 32'h0);
    chk("rst_async_trap", 32'(tr[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic flush_two(input logic [31:0] tgt);
    chk("fl1_flush", 32'(fl[0]), 32'd1);
    chk("fl1_pc", pcv[0], tgt);
    @(negedge clk);
    chk("fl2_flush", 32'(fl[0]), 32'd1);
    @(negedge clk);
    chk("fl3_flush", 32'(fl[0]), 32'd0);
    chk("fl3_req", 32'(req[0]), 32'd1);
  endtask

  initial begin
    logic [31:0] r1, r2;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pc", pcv[0], 32'h0);
    chk("rst_req", 32'(req[0]), 32'd0);
    chk("rst_iv", 32'(iv[0]), 32'd0);
    chk("rst_flush", 32'(fl[0]), 32'd0);
    chk("rst_trap_addr", ta[0], 32'h0);
    reset    = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    chk("first_fetch", 32'(req[0]), 32'd1);

    do_exec(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
    do_exec(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h4, 0);
    do_exec(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h8, 0);
    do_exec(0, 2'd2, 1'b0, 32'hF4, 32'h0, 32'hC, 0);
    flush_two(32'h100);

    do_exec(0, 2'd1, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h100, 0);
    flush_two(32'hF0);
    do_exec(0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hF0, 0);
    do_exec(0, 2'd1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h100, 0);
    chk("bnt_pc", pcv[0], 32'h104);
    chk("bnt_flush", 32'(fl[0]), 32'd0);
    chk("bnt_req", 32'(req[0]), 32'd1);

    do_exec(0, 2'd2, 1'b0, 32'hFFFF_FF1C, 32'h0, 32'h104, 0);
    do_exec(0, 2'd3, 1'b0, 32'h3, 32'h1001, 32'h20, 0);
    chk("jalr_ok_pc", pcv[0], 32'h1004);
    chk("jalr_ok_trap", 32'(tr[0]), 32'd0);
    do_exec(0, 2'd2, 1'b0, 32'hFFFF_F01C, 32'h0, 32'h1004, 0);
    do_exec(0, 2'd3, 1'b0, 32'h2, 32'h1001, 32'h20, 0);
    repeat (3) begin
      chk("trap_flag", 32'(tr[0]), 32'd1);
      chk("trap_addr", ta[0], 32'h1002);
      chk("trap_pc", pcv[0], 32'h20);
      chk("trap_req", 32'(req[0]), 32'd0);
      @(negedge clk);
    end

    do_reset();
    do_exec(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 3);
    do_exec(0, 2'd2, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h4, 0);
    do_exec(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0);
    chk("wrap_pc", pcv[0], 32'h0);
    chk("wrap_trap", 32'(tr[0]), 32'd0);

    imem_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_req", 32'(req[0]), 32'd1);
      chk("hold_iv", 32'(iv[0]), 32'd0);
    end
    do_reset();
    imem_ack = 1'b1;
    chk("post_rst_idle", 32'(req[0]), 32'd0);
    @(negedge clk);
    chk("post_rst_fetch", 32'(req[0]), 32'd1);

    do_exec(1, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 0);
    chk("d1_jal1_pc", pcv[1], 32'h40);
    chk("d1_jal1_req", 32'(req[1]), 32'd1);
    do_exec(1, 2'd2, 1'b0, 32'h8, 32'h0, 32'h40, 0);
    chk("d1_jal2_pc", pcv[1], 32'h48);
    chk("d1_jal2_flush", 32'(fl[1]), 32'd0);
    chk("d1_jal2_req", 32'(req[1]), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom % 150 == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
      end
      r1       = $urandom;
      r2       = $urandom;
      imem_ack = ($urandom % 10) < 7;
      stall    = ($urandom % 5) == 0;
      pc_src   = 2'($urandom % 4);
      branch   = 1'($urandom % 2);
      imm      = {{20{r1[11]}}, r1[11:2], 2'b00};
      if ($urandom % 8 == 0) imm[1:0] = r1[13:12];
      rs1      = {16'h0, r2[15:2], 2'b00};
      if ($urandom % 8 == 0) rs1[1:0] = r2[17:16];
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer side of the branch decision: takes the comparison unit's `branch` result plus decoder control, computes the next program counter, and sequences instruction fetch.
- Multi-cycle FSM: fetch handshake with instruction memory, execute window, post-redirect flush, misaligned-target trap.
- Sits between decode/branch comparison and instruction memory in the RV32I core.

Parameters:
- XLEN, 32, datapath/PC width
- RESET_VECTOR, 32'h0000_0000, PC value after reset
- FLUSH_CYCLES, 2, cycles `flush` is held after a taken redirect (0 = none, max 15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; address is pc
- imem_ack  in  1  instruction memory accepted/returned instruction
- instr_valid  out  1  high for each EXEC cycle; instruction at pc is valid
- stall  in  1  hold EXEC (e.g. data memory busy)
- pc_src  in  2  0 SEQ, 1 BRANCH, 2 JAL, 3 JALR (shared package codes)
- branch  in  1  comparison result, meaningful when pc_src=BRANCH
- imm  in  XLEN  sign-extended immediate
- rs1  in  XLEN  register operand for JALR
- pc  out  XLEN  current program counter
- pc_plus4  out  XLEN  pc+4 (combinational), link value for JAL/JALR
- flush  out  1  squash in-flight younger state
- trap  out  1  misaligned-target trap, sticky until reset
- trap_addr  out  XLEN  offending target address

Behaviour:
- Reset (async, immediate, including mid-fetch):
  - pc=RESET_VECTOR; state=IDLE.
  - imem_req=0, instr_valid=0, flush=0, trap=0, trap_addr=0.
- States and transitions:
  - IDLE: all outputs low; next cycle → FETCH.
  - FETCH: imem_req=1 (Moore); pc held. On imem_ack=1 → EXEC next cycle. Without ack, stay indefinitely.
  - EXEC: instr_valid=1.
    - stall=1: stay in EXEC, pc held.
    - stall=0: resolve next PC (below) and leave EXEC.
  - FLUSH: flush=1; 4-bit counter loaded with FLUSH_CYCLES-1 on entry. When counter=0 → FETCH, else decrement. Total flush high time = FLUSH_CYCLES cycles.
  - TRAP: terminal. trap=1, all other outputs low, pc frozen; leave only via reset.
- Next-PC resolution (EXEC, stall=0):
  - SEQ, or BRANCH with branch=0: pc<=pc+4 → FETCH.
  - BRANCH with branch=1, or JAL: target = pc+imm.
  - JALR: target = (rs1+imm) with bit 0 cleared.
- Taken redirect handling:
  - target[1:0]≠0: pc unchanged, trap_addr<=target → TRAP.
  - Otherwise pc<=target → FLUSH if FLUSH_CYCLES>0, else FETCH.
- Arithmetic: all adds modulo 2^XLEN; pc 0xFFFF_FFFC + 4 wraps to 0 with no trap. Negative imm wraps likewise.
- Sequential path never traps: pc stays word-aligned from an aligned RESET_VECTOR.
- imem_ack outside FETCH: ignored. An ack in the same cycle FETCH is entered counts only from the first FETCH cycle onward.
- pc_plus4 is valid in every state and is derived from the registered pc.
- branch is ignored unless pc_src=BRANCH.
- Latency, no stall, zero-wait memory:
  - Sequential instruction: 2 cycles (FETCH, EXEC).
  - Taken redirect: 2+FLUSH_CYCLES cycles.

Decomposition:
- Shared package/header (alongside the comparison codes):
  - pc_src codes SEQ/BRANCH/JAL/JALR
  - state encodings IDLE/FETCH/EXEC/FLUSH/TRAP
  - XLEN
- One natural sub-module: `next_pc_calc`, combinational. Computes target, taken, and misaligned from pc, pc_src, branch, imm, rs1.
- FSM, pc register, and flush counter stay in pc_sequencer.

Test Plan:
- Reset then ack every FETCH, pc_src=SEQ → pc sequence 0,4,8,12; instr_valid every 2nd cycle; imem_req high only in FETCH.
- pc=0x100, pc_src=BRANCH, imm=0xFFFF_FFF0, branch=1 → pc=0xF0, flush high exactly 2 cycles, then FETCH. Same stimulus with branch=0 → pc=0x104, no flush.
- pc=0x20, JALR, rs1=0x1001, imm=2 → pc=0x1002 is misaligned → TRAP, trap=1, trap_addr=0x1002, pc stays 0x20. JALR rs1=0x1001, imm=3 → pc=0x1004, no trap.
- pc=0xFFFF_FFFC, SEQ → pc=0x0000_0000, no trap. Stall=1 for 3 EXEC cycles → pc constant, instr_valid held high 4 cycles.
- Assert reset during FETCH with imem_ack withheld 5 cycles → outputs clear immediately (async); pc=RESET_VECTOR; after release, IDLE then FETCH.
- FLUSH_CYCLES=0 build, JAL imm=8 at pc=0x40 → pc=0x48, flush never asserted, FETCH the next cycle.
